hazard3_fetch_hw_buf: RTL and testbench
=======================================

HAZARD3_FETCH_HW_BUF -- requirements
Module: hazard3_fetch_hw_buf

Interface
REQ-001 SHALL have parameter DEPTH_HW, default 6, meaning halfword storage capacity; legal values are even numbers from 4 to 14.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port fetch_vld, input, 1 bit: fetch_data holds a valid 32-bit word-aligned bus fetch.
REQ-005 SHALL have port fetch_data, input, 32 bits: fetched word; bits 15:0 are the lower-addressed halfword.
REQ-006 SHALL have port fetch_rdy, output, 1 bit: buffer accepts fetch_data this cycle.
REQ-007 SHALL have port flush, input, 1 bit: discard all buffered and in-flight halfwords (jump/trap).
REQ-008 SHALL have port flush_addr1, input, 1 bit: bit 1 of the jump target; sampled only when flush=1.
REQ-009 SHALL have port cir, output, 32 bits: window to the decompressor; bits 15:0 are the oldest halfword.
REQ-010 SHALL have port cir_vld, output, 2 bits: count of valid halfwords in cir, 0..2.
REQ-011 SHALL have port cir_use, input, 2 bits: halfwords consumed this cycle, 0..2.
REQ-012 SHALL have port level, output, 4 bits: halfwords currently stored, 0..DEPTH_HW.

Function
REQ-013 SHALL store halfwords in FIFO order with a registered occupancy count `level`; there SHALL be no bypass, so data accepted in cycle N is visible on cir in cycle N+1 at the earliest.
REQ-014 SHALL drive fetch_rdy = (level <= DEPTH_HW-2) && !flush, combinationally from the registered level only (consumption in the same cycle SHALL NOT be credited).
REQ-015 SHALL treat a fetch as accepted when fetch_vld && fetch_rdy.
REQ-016 SHALL write 2 halfwords per accepted word, low half first.
REQ-017 SHALL write only fetch_data[31:16] when the skip_lo flag is set, then clear skip_lo.
REQ-018 SHALL set skip_lo to flush_addr1 on any cycle with flush=1, and SHALL clear it on reset.
REQ-019 SHALL drive cir_vld = min(level, 2).
REQ-020 SHALL drive cir[15:0] with the oldest halfword and cir[31:16] with the next-oldest.
REQ-021 SHALL drive 16'h0000 in any halfword lane whose halfword is not valid.
REQ-022 SHALL remove cir_use halfwords per cycle.
REQ-023 SHALL, when cir_use > cir_vld (illegal), remove only cir_vld halfwords; under HAZARD3_ASSERTIONS this SHALL fail an assertion.
REQ-024 SHALL, on simultaneous accept and consume in one cycle, update level to level + written - consumed, with no loss or duplication of halfwords.
REQ-025 SHALL, on flush, force level to 0 on the next edge, ignore cir_use, and discard any fetch presented in the same cycle (fetch_rdy is 0).
REQ-026 SHALL handle read and write pointer wrap at DEPTH_HW transparently; a full buffer (level=DEPTH_HW) SHALL hold data stably with fetch_rdy=0.
REQ-027 SHALL keep level within 0..DEPTH_HW at all times; overflow is impossible by construction of fetch_rdy.

Reset
REQ-028 SHALL, while rst_n=0, clear level, pointers and skip_lo, giving cir_vld=0, cir=32'h0 and fetch_rdy=1.
REQ-029 SHALL abandon all stored halfwords when reset is asserted mid-operation; storage contents need not be reset.

Verification
REQ-030 SHALL be verified by this scenario: after reset, fetch 32'hAAAA_1111, then 32'hBBBB_2222, with cir_use=0 -> cir=32'hAAAA_1111, cir_vld=2, level=4.
REQ-031 SHALL be verified by this scenario: with level=4 holding 1111, AAAA, 2222, BBBB, apply cir_use=1, then cir_use=2 -> cir shows 32'h2222_AAAA, then 32'h0000_BBBB with cir_vld=1.
REQ-032 SHALL be verified by this scenario: flush with flush_addr1=1, then fetch 32'hCCCC_DDDD -> level=1, cir=32'h0000_CCCC, cir_vld=1; the next fetch writes 2 halfwords.
REQ-033 SHALL be verified by this scenario: with DEPTH_HW=6, fetch continuously with cir_use=0 -> fetch_rdy drops when level=6; then a cycle with cir_use=2 plus an offered fetch -> fetch not accepted that cycle, and level=4.
REQ-034 SHALL be verified by this scenario: a flush coincident with fetch_vld=1 and cir_use=2 at level=5 -> next cycle level=0, cir_vld=0, and the fetch word is never presented.
REQ-035 SHALL be verified by this scenario: randomised fetch and consume traffic for at least 10k cycles against a halfword queue model -> cir matches the model every cycle, with read and write pointers wrapping at least 100 times.

Source files
------------

// File: rtl/hazard3_fetch_hw_buf.sv
// Halfword prefetch buffer between the 32-bit fetch bus and the decompressor.
// Words are split into halfwords and queued in FIFO order; the two oldest
// halfwords are presented on cir. A flush drops everything and may mark the
// low half of the next fetched word as skipped (jump to an odd halfword).
module hazard3_fetch_hw_buf #(
    parameter int DEPTH_HW = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_vld,
    input  logic [31:0] fetch_data,
    output logic        fetch_rdy,
    input  logic        flush,
    input  logic        flush_addr1,
    output logic [31:0] cir,
    output logic [1:0]  cir_vld,
    input  logic [1:0]  cir_use,
    output logic [3:0]  level
);

    localparam int             PW       = $clog2(DEPTH_HW);
    localparam logic [3:0]     WR_LIMIT = 4'(DEPTH_HW - 2);
    localparam logic [PW:0]    DEPTH_P  = (PW + 1)'(DEPTH_HW);

    // Pointer advance modulo DEPTH_HW (depth need not be a power of two).
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] n);
        logic [PW:0] sum;
        sum = {1'b0, ptr} + {{(PW - 1){1'b0}}, n};
        if (sum >= DEPTH_P)
            sum = sum - DEPTH_P;
        return sum[PW-1:0];
    endfunction

    logic [15:0]   mem [DEPTH_HW];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [3:0]    level_q;
    logic          skip_lo;
    logic          accept;
    logic [1:0]    vld_cnt;
    logic [1:0]    n_wr;
    logic [1:0]    n_rd;

    // Handshake and per-cycle write/remove counts; only registered level gates ready.
    always_comb begin
        fetch_rdy = (level_q <= WR_LIMIT) && !flush;
        accept    = fetch_vld && fetch_rdy;
        vld_cnt   = (level_q >= 4'd2) ? 2'd2 : level_q[1:0];
        n_wr      = accept ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
        // Over-consumption is clamped to what is actually visible.
        n_rd      = flush ? 2'd0 : ((cir_use > vld_cnt) ? vld_cnt : cir_use);
    end

    // Occupancy, pointers and the skip-low-half flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 4'd0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            skip_lo <= 1'b0;
        end else if (flush) begin
            level_q <= 4'd0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            skip_lo <= flush_addr1;
        end else begin
            level_q <= level_q + {2'b00, n_wr} - {2'b00, n_rd};
            rd_ptr  <= ptr_add(rd_ptr, n_rd);
            wr_ptr  <= ptr_add(wr_ptr, n_wr);
            if (accept)
                skip_lo <= 1'b0;
        end
    end

    // Halfword storage; contents are don't-care while level says empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (skip_lo) begin
                mem[wr_ptr] <= fetch_data[31:16];
            end else begin
                mem[wr_ptr]                <= fetch_data[15:0];
                mem[ptr_add(wr_ptr, 2'd1)] <= fetch_data[31:16];
            end
        end
    end

    // Present the two oldest halfwords, zeroing lanes that hold nothing valid.
    always_comb begin
        cir[15:0]  = (level_q != 4'd0) ? mem[rd_ptr] : 16'h0000;
        cir[31:16] = (level_q >= 4'd2) ? mem[ptr_add(rd_ptr, 2'd1)] : 16'h0000;
        cir_vld    = vld_cnt;
        level      = level_q;
    end

`ifdef HAZARD3_ASSERTIONS
    // The decoder must never consume more halfwords than are visible.
    always @(posedge clk) begin
        if (rst_n && !flush)
            assert (cir_use <= cir_vld);
    end
`endif

endmodule

// File: tb/tb_hazard3_fetch_hw_buf.sv
// Self-checking bench for hazard3_fetch_hw_buf: directed scenarios plus
// randomised traffic compared against a halfword-queue reference model.
module tb_hazard3_fetch_hw_buf;

    localparam int DEPTH = 6;

    logic        clk;
    logic        rst_n;
    logic        fetch_vld;
    logic [31:0] fetch_data;
    logic        fetch_rdy;
    logic        flush;
    logic        flush_addr1;
    logic [31:0] cir;
    logic [1:0]  cir_vld;
    logic [1:0]  cir_use;
    logic [3:0]  level;

    int checks   = 0;
    int failures = 0;
    int hw_written = 0;

    // Reference model: queue of halfwords, oldest at index 0.
    logic [15:0] q[$];
    bit          m_skip;

    hazard3_fetch_hw_buf #(.DEPTH_HW(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_vld(fetch_vld), .fetch_data(fetch_data),
        .fetch_rdy(fetch_rdy), .flush(flush), .flush_addr1(flush_addr1),
        .cir(cir), .cir_vld(cir_vld), .cir_use(cir_use), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_rdy();
        return (q.size() <= DEPTH - 2) && !flush;
    endfunction

    function automatic logic [1:0] m_vld();
        return (q.size() >= 2) ? 2'd2 : 2'(q.size());
    endfunction

    function automatic logic [3:0] m_level();
        return 4'(q.size());
    endfunction

    function automatic logic [31:0] m_cir();
        logic [31:0] r;
        r = 32'h0;
        if (q.size() > 0) r[15:0]  = q[0];
        if (q.size() > 1) r[31:16] = q[1];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic f,
                         input logic a1, input logic [1:0] u);
        fetch_vld = v; fetch_data = d; flush = f; flush_addr1 = a1; cir_use = u;
        #1;
    endtask

    // Advance one clock and apply the same transaction to the model.
    task automatic tick();
        logic rdy;
        int   avail;
        int   n;
        rdy = m_rdy();
        @(posedge clk);
        if (flush) begin
            q.delete();
            m_skip = flush_addr1;
        end else begin
            avail = (q.size() < 2) ? q.size() : 2;
            n = (int'(cir_use) > avail) ? avail : int'(cir_use);
            repeat (n) void'(q.pop_front());
            if (fetch_vld && rdy) begin
                if (!m_skip) begin
                    q.push_back(fetch_data[15:0]);
                    hw_written++;
                end
                q.push_back(fetch_data[31:16]);
                hw_written++;
                m_skip = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        q.delete(); m_skip = 1'b0;
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (cir_vld !== 2'd0) begin failures++; $display("FAIL reset_cir_vld got=%0d exp=0", cir_vld); end
        checks++; if (cir !== 32'h0) begin failures++; $display("FAIL reset_cir got=%h exp=00000000", cir); end
        checks++; if (fetch_rdy !== 1'b1) begin failures++; $display("FAIL reset_fetch_rdy got=%b exp=1", fetch_rdy); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        drive(1'b1, 32'hAAAA_1111, 1'b0, 1'b0, 2'd0);
        checks++; if (cir_vld !== 2'd0) begin failures++; $display("FAIL fill_no_bypass got=%0d exp=0", cir_vld); end
        tick();
        drive(1'b1, 32'hBBBB_2222, 1'b0, 1'b0, 2'd0);
        checks++; if (cir !== 32'hAAAA_1111) begin failures++; $display("FAIL fill_first_word got=%h exp=aaaa1111", cir); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (cir !== 32'hAAAA_1111) begin failures++; $display("FAIL fill_cir got=%h exp=aaaa1111", cir); end
        checks++; if (cir_vld !== 2'd2) begin failures++; $display("FAIL fill_cir_vld got=%0d exp=2", cir_vld); end
        checks++; if (level !== 4'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
    endtask

    task automatic test_consume();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        tick();
        checks++; if (cir !== 32'h2222_AAAA) begin failures++; $display("FAIL consume1_cir got=%h exp=2222aaaa", cir); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (cir !== 32'h0000_BBBB) begin failures++; $display("FAIL consume2_cir got=%h exp=0000bbbb", cir); end
        checks++; if (cir_vld !== 2'd1) begin failures++; $display("FAIL consume2_cir_vld got=%0d exp=1", cir_vld); end
    endtask

    task automatic test_skip_lo();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'd0);
        tick();
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL skip_flush_level got=%0d exp=0", level); end
        drive(1'b1, 32'hCCCC_DDDD, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 4'd1) begin failures++; $display("FAIL skip_level got=%0d exp=1", level); end
        checks++; if (cir !== 32'h0000_CCCC) begin failures++; $display("FAIL skip_cir got=%h exp=0000cccc", cir); end
        checks++; if (cir_vld !== 2'd1) begin failures++; $display("FAIL skip_cir_vld got=%0d exp=1", cir_vld); end
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 4'd3) begin failures++; $display("FAIL skip_next_level got=%0d exp=3", level); end
        checks++; if (cir !== 32'h5678_CCCC) begin failures++; $display("FAIL skip_next_cir got=%h exp=5678cccc", cir); end
    endtask

    task automatic test_full();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1000_0001 * (i + 1), 1'b0, 1'b0, 2'd0);
            tick();
        end
        drive(1'b1, 32'hFFFF_EEEE, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 4'd6) begin failures++; $display("FAIL full_level got=%0d exp=6", level); end
        checks++; if (fetch_rdy !== 1'b0) begin failures++; $display("FAIL full_rdy got=%b exp=0", fetch_rdy); end
        tick();
        drive(1'b1, 32'hFFFF_EEEE, 1'b0, 1'b0, 2'd2);
        checks++; if (cir !== 32'h1000_0001) begin failures++; $display("FAIL full_hold_cir got=%h exp=10000001", cir); end
        checks++; if (fetch_rdy !== 1'b0) begin failures++; $display("FAIL full_use_rdy got=%b exp=0", fetch_rdy); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 4'd4) begin failures++; $display("FAIL full_use_level got=%0d exp=4", level); end
        checks++; if (cir !== 32'h2000_0002) begin failures++; $display("FAIL full_use_cir got=%h exp=20000002", cir); end
        checks++; if (fetch_rdy !== 1'b1) begin failures++; $display("FAIL full_reopen_rdy got=%b exp=1", fetch_rdy); end
    endtask

    task automatic test_flush_collide();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0101_0101 * (i + 3), 1'b0, 1'b0, 2'd0);
            tick();
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2);
        checks++; if (level !== 4'd5) begin failures++; $display("FAIL collide_pre_level got=%0d exp=5", level); end
        checks++; if (fetch_rdy !== 1'b0) begin failures++; $display("FAIL collide_rdy got=%b exp=0", fetch_rdy); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL collide_level got=%0d exp=0", level); end
        checks++; if (cir_vld !== 2'd0) begin failures++; $display("FAIL collide_cir_vld got=%0d exp=0", cir_vld); end
        tick();
        drive(1'b1, 32'h1357_2468, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (cir !== 32'h1357_2468) begin failures++; $display("FAIL collide_next_cir got=%h exp=13572468", cir); end
    endtask

    task automatic test_illegal_use();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
        checks++; if (cir_vld !== 2'd1) begin failures++; $display("FAIL illegal_pre_vld got=%0d exp=1", cir_vld); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL illegal_level got=%0d exp=0", level); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL illegal_empty_level got=%0d exp=0", level); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h5555_6666, 1'b1, 1'b1, 2'd0);
        tick();
        drive(1'b1, 32'h7777_8888, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        q.delete(); m_skip = 1'b0;
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL midreset_level got=%0d exp=0", level); end
        checks++; if (cir !== 32'h0) begin failures++; $display("FAIL midreset_cir got=%h exp=00000000", cir); end
        checks++; if (fetch_rdy !== 1'b1) begin failures++; $display("FAIL midreset_rdy got=%b exp=1", fetch_rdy); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 32'h9999_AAAA, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        checks++; if (cir !== 32'h9999_AAAA) begin failures++; $display("FAIL midreset_skip_clear got=%h exp=9999aaaa", cir); end
    endtask

    task automatic test_random();
        logic v, f, a1;
        logic [1:0] u;
        hw_written = 0;
        for (int c = 0; c < 12000; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 63) == 0);
            a1 = 1'($urandom_range(0, 1));
            u  = 2'($urandom_range(0, int'(m_vld())));
            drive(v, $urandom, f, a1, u);
            checks++; if (cir !== m_cir()) begin failures++; $display("FAIL rand_cir cyc=%0d got=%h exp=%h", c, cir, m_cir()); end
            checks++; if (cir_vld !== m_vld()) begin failures++; $display("FAIL rand_cir_vld cyc=%0d got=%0d exp=%0d", c, cir_vld, m_vld()); end
            checks++; if (level !== m_level()) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", c, level, m_level()); end
            checks++; if (fetch_rdy !== m_rdy()) begin failures++; $display("FAIL rand_rdy cyc=%0d got=%b exp=%b", c, fetch_rdy, m_rdy()); end
            tick();
        end
        checks++;
        if (hw_written < 100 * DEPTH) begin
            failures++;
            $display("FAIL rand_wraps got=%0d halfwords exp>=%0d", hw_written, 100 * DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume();
        test_skip_lo();
        test_full();
        test_flush_collide();
        test_illegal_use();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
